// File: rtl/cpu_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pc_unit
// Purpose  : Program-counter unit. Presents sequential fetch addresses,
//            redirects on taken branch/jal/jalr from the execute stage,
//            inserts one FLUSH bubble after every redirect, traps to
//            TRAP_VECTOR on a misaligned taken target, and counts executed
//            and taken conditional branches.
// Ports    : clk, rst (async, active-high)
//            stall                       - freeze everything
//            inst_valid, is_branch, is_jal, is_jalr, condition_satisfied
//            exec_pc, imm, rs1_value     - execute-stage operands (32b)
//            fetch_ready                 - fetch accepts pc this cycle
//            pc, fetch_valid             - fetch request
//            flush, misaligned_trap      - one-cycle pulses
//            branch_count, taken_count   - 32b wrapping counters
// Revision : 1.0 - initial release
// ============================================================================
module cpu_pc_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0010
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        inst_valid,
  input  logic        is_branch,
  input  logic        is_jal,
  input  logic        is_jalr,
  input  logic        condition_satisfied,
  input  logic [31:0] exec_pc,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_value,
  input  logic        fetch_ready,
  output logic [31:0] pc,
  output logic        fetch_valid,
  output logic        flush,
  output logic        misaligned_trap,
  output logic [31:0] branch_count,
  output logic [31:0] taken_count
);

  localparam logic [0:0] c_RUN   = 1'b0;
  localparam logic [0:0] c_FLUSH = 1'b1;

  logic [0:0]  r_state;
  logic        w_active;
  logic        w_sel_jalr;
  logic        w_sel_jal;
  logic        w_sel_br;
  logic        w_taken;
  logic [31:0] w_jalr_sum;
  logic [31:0] w_target;
  logic        w_misaligned;

  // An instruction is only acted on in RUN; in FLUSH it is wrong-path.
  assign w_active   = (r_state == c_RUN) && !stall && inst_valid;

  // Class priority: jalr over jal over branch.
  assign w_sel_jalr = is_jalr;
  assign w_sel_jal  = !is_jalr && is_jal;
  assign w_sel_br   = !is_jalr && !is_jal && is_branch;

  assign w_taken    = w_active &&
                      (w_sel_jalr || w_sel_jal || (w_sel_br && condition_satisfied));

  assign w_jalr_sum = rs1_value + imm;
  assign w_target   = w_sel_jalr ? {w_jalr_sum[31:1], 1'b0} : (exec_pc + imm);
  assign w_misaligned = (w_target[1:0] != 2'b00);

  // fetch_valid is a pure decode of the registered state.
  assign fetch_valid = (r_state == c_RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= c_RUN;
      pc              <= RESET_PC;
      flush           <= 1'b0;
      misaligned_trap <= 1'b0;
      branch_count    <= 32'd0;
      taken_count     <= 32'd0;
    end else begin
      // Pulses default low; also guarantees no pulse is generated under stall.
      flush           <= 1'b0;
      misaligned_trap <= 1'b0;
      if (!stall) begin
        case (r_state)
          c_RUN: begin
            if (w_taken) begin
              // Redirect does not wait for fetch_ready.
              pc              <= w_misaligned ? TRAP_VECTOR : w_target;
              flush           <= 1'b1;
              misaligned_trap <= w_misaligned;
              r_state         <= c_FLUSH;
            end else if (fetch_ready) begin
              pc <= pc + 32'd4;  // wraps naturally at 2^32
            end
            if (w_active && w_sel_br) begin
              branch_count <= branch_count + 32'd1;
              if (condition_satisfied) begin
                taken_count <= taken_count + 32'd1;
              end
            end
          end
          c_FLUSH: begin
            r_state <= c_RUN;
          end
          default: begin
            r_state <= c_RUN;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_pc_unit
// Purpose  : Directed self-checking bench for cpu_pc_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_pc_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        inst_valid;
  logic        is_branch;
  logic        is_jal;
  logic        is_jalr;
  logic        condition_satisfied;
  logic [31:0] exec_pc;
  logic [31:0] imm;
  logic [31:0] rs1_value;
  logic        fetch_ready;
  logic [31:0] pc;
  logic        fetch_valid;
  logic        flush;
  logic        misaligned_trap;
  logic [31:0] branch_count;
  logic [31:0] taken_count;

  int total;
  int bad;

  cpu_pc_unit #(
    .RESET_PC    (32'h0000_0000),
    .TRAP_VECTOR (32'h0000_0010)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .stall               (stall),
    .inst_valid          (inst_valid),
    .is_branch           (is_branch),
    .is_jal              (is_jal),
    .is_jalr             (is_jalr),
    .condition_satisfied (condition_satisfied),
    .exec_pc             (exec_pc),
    .imm                 (imm),
    .rs1_value           (rs1_value),
    .fetch_ready         (fetch_ready),
    .pc                  (pc),
    .fetch_valid         (fetch_valid),
    .flush               (flush),
    .misaligned_trap     (misaligned_trap),
    .branch_count        (branch_count),
    .taken_count         (taken_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    inst_valid = 0; is_branch = 0; is_jal = 0; is_jalr = 0;
    condition_satisfied = 0; exec_pc = 0; imm = 0; rs1_value = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; stall = 0; fetch_ready = 0;
    idle_inputs();
    #2;
    total++;
    if (pc !== 32'h0 || fetch_valid !== 1'b1 || flush !== 1'b0 || misaligned_trap !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs pc=%h fv=%b fl=%b tr=%b required pc=0 fv=1 fl=0 tr=0",
               pc, fetch_valid, flush, misaligned_trap);
    end
    total++;
    if (branch_count !== 32'd0 || taken_count !== 32'd0) begin
      bad++;
      $display("FAIL reset_counts bc=%0d tc=%0d required 0 0", branch_count, taken_count);
    end
    step();
    step();
    total++;
    if (pc !== 32'h0) begin
      bad++;
      $display("FAIL reset_hold pc=%h required 0", pc);
    end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'h4; exp_pc[1] = 32'h8; exp_pc[2] = 32'hC;
    fetch_ready = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (pc !== exp_pc[i] || fetch_valid !== 1'b1) begin
        bad++;
        $display("FAIL seq_pc%0d pc=%h fv=%b required pc=%h fv=1", i, pc, fetch_valid, exp_pc[i]);
      end
    end
    fetch_ready = 0;
    step();
    total++;
    if (pc !== 32'hC) begin
      bad++;
      $display("FAIL seq_hold pc=%h required 0000000c", pc);
    end
  endtask

  task automatic test_taken_branch();
    fetch_ready = 1;
    inst_valid = 1; is_branch = 1; condition_satisfied = 1;
    exec_pc = 32'h100; imm = 32'h20;
    step();
    total++;
    if (pc !== 32'h120 || flush !== 1'b1 || fetch_valid !== 1'b0 || misaligned_trap !== 1'b0) begin
      bad++;
      $display("FAIL br_taken pc=%h fl=%b fv=%b tr=%b required pc=120 fl=1 fv=0 tr=0",
               pc, flush, fetch_valid, misaligned_trap);
    end
    total++;
    if (branch_count !== 32'd1 || taken_count !== 32'd1) begin
      bad++;
      $display("FAIL br_taken_counts bc=%0d tc=%0d required 1 1", branch_count, taken_count);
    end
    // Inputs left asserted: must be ignored as wrong-path during FLUSH.
    step();
    total++;
    if (pc !== 32'h120 || flush !== 1'b0 || fetch_valid !== 1'b1 || branch_count !== 32'd1) begin
      bad++;
      $display("FAIL br_flush_cycle pc=%h fl=%b fv=%b bc=%0d required pc=120 fl=0 fv=1 bc=1",
               pc, flush, fetch_valid, branch_count);
    end
  endtask

  task automatic test_not_taken();
    fetch_ready = 1;
    inst_valid = 1; is_branch = 1; condition_satisfied = 0;
    exec_pc = 32'h100; imm = 32'h20;
    step();
    total++;
    if (pc !== 32'h124 || flush !== 1'b0 || fetch_valid !== 1'b1) begin
      bad++;
      $display("FAIL br_not_taken pc=%h fl=%b fv=%b required pc=124 fl=0 fv=1", pc, flush, fetch_valid);
    end
    total++;
    if (branch_count !== 32'd2 || taken_count !== 32'd1) begin
      bad++;
      $display("FAIL br_nt_counts bc=%0d tc=%0d required 2 1", branch_count, taken_count);
    end
    idle_inputs();
  endtask

  task automatic test_jalr();
    // All class bits set: jalr wins; jal/branch would target aligned 0x100.
    fetch_ready = 0;
    inst_valid = 1; is_jalr = 1; is_jal = 1; is_branch = 1; condition_satisfied = 1;
    rs1_value = 32'h203; imm = 32'h0; exec_pc = 32'h100;
    step();
    total++;
    if (pc !== 32'h10 || flush !== 1'b1 || misaligned_trap !== 1'b1) begin
      bad++;
      $display("FAIL jalr_trap pc=%h fl=%b tr=%b required pc=10 fl=1 tr=1", pc, flush, misaligned_trap);
    end
    total++;
    if (branch_count !== 32'd2 || taken_count !== 32'd1) begin
      bad++;
      $display("FAIL jalr_counts bc=%0d tc=%0d required 2 1", branch_count, taken_count);
    end
    idle_inputs();
    step();
    total++;
    if (misaligned_trap !== 1'b0 || flush !== 1'b0 || pc !== 32'h10) begin
      bad++;
      $display("FAIL jalr_pulse_end tr=%b fl=%b pc=%h required 0 0 10", misaligned_trap, flush, pc);
    end
    // Aligned jalr: (0x301 + 0x10) & ~1 = 0x310.
    inst_valid = 1; is_jalr = 1; rs1_value = 32'h301; imm = 32'h10;
    step();
    total++;
    if (pc !== 32'h310 || misaligned_trap !== 1'b0 || flush !== 1'b1) begin
      bad++;
      $display("FAIL jalr_aligned pc=%h tr=%b fl=%b required pc=310 tr=0 fl=1", pc, misaligned_trap, flush);
    end
    idle_inputs();
    step();
    // Misaligned taken branch: 0x100 + 0x2.
    inst_valid = 1; is_branch = 1; condition_satisfied = 1; exec_pc = 32'h100; imm = 32'h2;
    step();
    total++;
    if (pc !== 32'h10 || misaligned_trap !== 1'b1 || taken_count !== 32'd2 || branch_count !== 32'd3) begin
      bad++;
      $display("FAIL br_misaligned pc=%h tr=%b tc=%0d bc=%0d required pc=10 tr=1 tc=2 bc=3",
               pc, misaligned_trap, taken_count, branch_count);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_stall();
    fetch_ready = 1;
    stall = 1;
    inst_valid = 1; is_jal = 1; exec_pc = 32'h400; imm = 32'h40;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (pc !== 32'h10 || flush !== 1'b0 || fetch_valid !== 1'b1) begin
        bad++;
        $display("FAIL stall_hold%0d pc=%h fl=%b fv=%b required pc=10 fl=0 fv=1", i, pc, flush, fetch_valid);
      end
    end
    stall = 0;
    step();
    total++;
    if (pc !== 32'h440 || flush !== 1'b1 || fetch_valid !== 1'b0) begin
      bad++;
      $display("FAIL stall_release pc=%h fl=%b fv=%b required pc=440 fl=1 fv=0", pc, flush, fetch_valid);
    end
    idle_inputs();
    // Stall also freezes the FLUSH state.
    stall = 1;
    step();
    total++;
    if (fetch_valid !== 1'b0 || pc !== 32'h440) begin
      bad++;
      $display("FAIL stall_in_flush fv=%b pc=%h required fv=0 pc=440", fetch_valid, pc);
    end
    stall = 0;
    step();
    total++;
    if (fetch_valid !== 1'b1 || pc !== 32'h440) begin
      bad++;
      $display("FAIL flush_exit fv=%b pc=%h required fv=1 pc=440", fetch_valid, pc);
    end
  endtask

  task automatic test_wrap();
    fetch_ready = 1;
    inst_valid = 1; is_jal = 1; exec_pc = 32'hFFFF_FFF0; imm = 32'hC;
    step();
    idle_inputs();
    total++;
    if (pc !== 32'hFFFF_FFFC) begin
      bad++;
      $display("FAIL wrap_target pc=%h required fffffffc", pc);
    end
    step();
    step();
    total++;
    if (pc !== 32'h0) begin
      bad++;
      $display("FAIL wrap_pc pc=%h required 0", pc);
    end
  endtask

  task automatic test_reset_in_flush();
    fetch_ready = 1;
    inst_valid = 1; is_jal = 1; exec_pc = 32'h800; imm = 32'h8;
    step();
    idle_inputs();
    total++;
    if (fetch_valid !== 1'b0 || pc !== 32'h808) begin
      bad++;
      $display("FAIL pre_reset_flush fv=%b pc=%h required fv=0 pc=808", fetch_valid, pc);
    end
    rst = 1;
    #1;
    total++;
    if (pc !== 32'h0 || fetch_valid !== 1'b1 || flush !== 1'b0 || branch_count !== 32'd0 || taken_count !== 32'd0) begin
      bad++;
      $display("FAIL reset_mid_flush pc=%h fv=%b fl=%b bc=%0d tc=%0d required 0 1 0 0 0",
               pc, fetch_valid, flush, branch_count, taken_count);
    end
    @(negedge clk);
    rst = 0;
    step();
    total++;
    if (pc !== 32'h4 || fetch_valid !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_resume pc=%h fv=%b required pc=4 fv=1", pc, fetch_valid);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_sequential();
    test_taken_branch();
    test_not_taken();
    test_jalr();
    test_stall();
    test_wrap();
    test_reset_in_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cpu_pc_unit.md
CPU_PC_UNIT -- requirements
Module: cpu_pc_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC loaded on reset.
REQ-002 SHALL have parameter TRAP_VECTOR, default 32'h0000_0010, the PC loaded on a misaligned-target trap.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port stall  input  1  freezes the PC, the state and the counters while high.
REQ-006 SHALL have port inst_valid  input  1  the execute stage holds a valid instruction.
REQ-007 SHALL have ports is_branch, is_jal, is_jalr  input  1 each  control-transfer class of the execute instruction.
REQ-008 SHALL have port condition_satisfied  input  1  branch outcome from the branch tester.
REQ-009 SHALL have ports exec_pc, imm, rs1_value  input  32 each  execute-instruction PC, immediate, rs1 operand.
REQ-010 SHALL have port fetch_ready  input  1  fetch accepts the presented PC this cycle.
REQ-011 SHALL have port pc  output  32  address presented to fetch.
REQ-012 SHALL have port fetch_valid  output  1  pc is valid for fetch.
REQ-013 SHALL have port flush  output  1  one-cycle pulse that kills younger in-flight instructions.
REQ-014 SHALL have port misaligned_trap  output  1  one-cycle pulse on a misaligned taken target.
REQ-015 SHALL have ports branch_count, taken_count  output  32 each  executed conditional branches and taken conditional branches.

Function
REQ-016 SHALL implement states RUN and FLUSH, with state, pc and outputs registered.
REQ-017 SHALL drive fetch_valid=1 in RUN and fetch_valid=0 in FLUSH.
REQ-018 SHALL take a transfer when, in RUN with stall=0 and inst_valid=1, is_jal=1, is_jalr=1, or is_branch=1 with condition_satisfied=1.
REQ-019 SHALL apply class priority jalr > jal > branch when more than one class bit is set.
REQ-020 SHALL compute the target as exec_pc+imm for branch/jal and (rs1_value+imm) with bit 0 cleared for jalr, all modulo 2^32.
REQ-021 SHALL, on a taken transfer with target[1:0]==0, load pc<=target, pulse flush and enter FLUSH in the next cycle.
REQ-022 SHALL, on a taken transfer with target[1:0]!=0, load pc<=TRAP_VECTOR, pulse flush and misaligned_trap, and enter FLUSH.
REQ-023 SHALL, in RUN with stall=0, fetch_ready=1 and no taken transfer, load pc<=pc+4, wrapping 32'hFFFF_FFFC to 32'h0.
REQ-024 SHALL hold pc in RUN when fetch_ready=0 and there is no transfer; a redirect SHALL NOT wait for fetch_ready.
REQ-025 SHALL, in FLUSH with stall=0, return to RUN after exactly one cycle with pc unchanged, ignoring inst_valid as wrong-path.
REQ-026 SHALL, while stall=1, hold state, pc, and both counters, and drive flush=0 and misaligned_trap=0.
REQ-027 SHALL increment branch_count for each RUN, stall=0, inst_valid=1 cycle whose selected class is branch, and taken_count when that branch is also taken; both wrap at 2^32.
REQ-028 SHALL make the redirect visible on pc in the cycle after the decision, giving a branch penalty of one FLUSH bubble.

Reset
REQ-029 SHALL, while rst=1, immediately force pc=RESET_PC, state=RUN, fetch_valid=1, flush=0, misaligned_trap=0, branch_count=0 and taken_count=0, including mid-FLUSH.
REQ-030 SHALL resume normal operation at the first rising clk edge after rst deasserts.

Verification
REQ-031 SHALL verify sequential fetch: reset, then fetch_ready=1 for 3 cycles -> pc=0x0, 0x4, 0x8, 0xC.
REQ-032 SHALL verify a taken branch: exec_pc=0x100, imm=0x20, is_branch=1, condition_satisfied=1 -> pc=0x120 next cycle, flush pulse, one fetch_valid=0 cycle, taken_count=1.
REQ-033 SHALL verify a not-taken branch: same stimulus with condition_satisfied=0 -> pc=pc+4, no flush, branch_count=1, taken_count=0.
REQ-034 SHALL verify jalr: rs1_value=0x203, imm=0 -> pc=0x202, which is misaligned, so pc=TRAP_VECTOR with flush and misaligned_trap pulses.
REQ-035 SHALL verify stall: taken jal with stall=1 -> no pc change and no flush; when stall drops the redirect occurs.
REQ-036 SHALL verify reset during FLUSH: assert rst -> pc=RESET_PC and fetch_valid=1 immediately, with counters cleared.
